// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants, ALUOp encodings and control bundle for the register-read stage
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_JUMP  = 2'b11
    } aluop_e;

    // Field order fixes the bit layout of out_ctrl, MSB first.
    typedef struct packed {
        logic   reg_dst;
        logic   branch;
        logic   mem_read;
        logic   mem_to_reg;
        logic   mem_write;
        logic   jump;
        logic   alu_src;
        logic   reg_write;
        aluop_e alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
    } decode_t;

    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d = '0;
        unique case (op)
            OP_RTYPE: begin
                d.ctrl.reg_dst   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                d.ctrl.mem_write = 1'b1;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                d.ctrl.branch = 1'b1;
                d.ctrl.alu_op = ALUOP_SUB;
            end
            OP_J: begin
                d.ctrl.jump   = 1'b1;
                d.ctrl.alu_op = ALUOP_JUMP;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - architectural register array: two async read ports, one sync write port, r0 hardwired to zero
module reg_bank #(
    parameter int  DATA_W = 32,
    parameter int  NREGS  = 32,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // r0 is forced at the read mux so it stays zero regardless of array contents.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - one-entry decode/register-read pipeline stage; REG_READ_BYPASS_EN forwards same-cycle writeback
module reg_read_stage
    import mips_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  NREGS  = 32,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [AW-1:0]     out_dst,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_funct,
    output logic [9:0]        out_ctrl,
    output logic              out_illegal
);

    logic [AW-1:0]     rs_addr;
    logic [AW-1:0]     rt_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rs_rdata;
    logic [DATA_W-1:0] rt_rdata;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [AW-1:0]     dst_sel;
    decode_t           dec;
    ctrl_t             ctrl_q;
    logic              accept;
    logic              unused_instr;

    // Upper register-specifier bits are dropped when fewer than 32 registers exist.
    assign rs_addr = instr[21 +: AW];
    assign rt_addr = instr[16 +: AW];
    assign rd_addr = instr[11 +: AW];
    assign unused_instr = ^instr;

    reg_bank #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs_addr),
        .rd_data_a (rs_rdata),
        .rd_addr_b (rt_addr),
        .rd_data_b (rt_rdata),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

`ifdef REG_READ_BYPASS_EN
    logic wb_live;
    assign wb_live = wb_en && (wb_addr != '0);
    assign rs_val  = (wb_live && (wb_addr == rs_addr)) ? wb_data : rs_rdata;
    assign rt_val  = (wb_live && (wb_addr == rt_addr)) ? wb_data : rt_rdata;
`else
    assign rs_val = rs_rdata;
    assign rt_val = rt_rdata;
`endif

    assign dec      = decode_op(instr[31:26]);
    assign imm_ext  = DATA_W'($signed(instr[15:0]));
    assign dst_sel  = dec.ctrl.reg_dst ? rd_addr : rt_addr;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operands are latched at accept, so later writebacks cannot disturb a held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_imm     <= '0;
            out_dst     <= '0;
            out_opcode  <= '0;
            out_funct   <= '0;
            ctrl_q      <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_rs_data <= rs_val;
            out_rt_data <= rt_val;
            out_imm     <= imm_ext;
            out_dst     <= dst_sel;
            out_opcode  <= instr[31:26];
            out_funct   <= instr[5:0];
            ctrl_q      <= dec.ctrl;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    assign out_ctrl = ctrl_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - randomized self-checking bench for reg_read_stage against a behavioural model
module tb_reg_read_stage;

    localparam logic [9:0] C_REGDST   = 10'h200;
    localparam logic [9:0] C_BRANCH   = 10'h100;
    localparam logic [9:0] C_MEMREAD  = 10'h080;
    localparam logic [9:0] C_MEMTOREG = 10'h040;
    localparam logic [9:0] C_MEMWRITE = 10'h020;
    localparam logic [9:0] C_JUMP     = 10'h010;
    localparam logic [9:0] C_ALUSRC   = 10'h008;
    localparam logic [9:0] C_REGWRITE = 10'h004;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [9:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs_data;
    logic [31:0] out_rt_data;
    logic [31:0] out_imm;
    logic [4:0]  out_dst;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [9:0]  out_ctrl;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];
    logic        m_valid;
    exp_t        m_exp;

    reg_read_stage #(.DATA_W(32), .NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs_data (out_rs_data),
        .out_rt_data (out_rt_data),
        .out_imm     (out_imm),
        .out_dst     (out_dst),
        .out_opcode  (out_opcode),
        .out_funct   (out_funct),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t got_vec();
        return {out_rs_data, out_rt_data, out_imm, out_dst, out_opcode,
                out_funct, out_ctrl, out_illegal};
    endfunction

    // Register value the stage should capture for a source specifier this cycle.
    function automatic logic [31:0] read_model(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REG_READ_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    function automatic exp_t predict(input logic [31:0] ins);
        exp_t e;
        e.op  = ins[31:26];
        e.fn  = ins[5:0];
        e.rs  = read_model(ins[25:21]);
        e.rt  = read_model(ins[20:16]);
        e.imm = {{16{ins[15]}}, ins[15:0]};
        e.ill = 1'b0;
        case (e.op)
            6'b000000: e.ctrl = C_REGDST | C_REGWRITE | 10'd2;
            6'b100011: e.ctrl = C_MEMREAD | C_MEMTOREG | C_ALUSRC | C_REGWRITE;
            6'b101011: e.ctrl = C_MEMWRITE | C_ALUSRC;
            6'b000100: e.ctrl = C_BRANCH | 10'd1;
            6'b000010: e.ctrl = C_JUMP | 10'd3;
            default: begin
                e.ctrl = 10'h0;
                e.ill  = 1'b1;
            end
        endcase
        e.dst = (e.ctrl & C_REGDST) != 0 ? ins[15:11] : ins[20:16];
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_exp   = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    endtask

    // Advance one clock with the currently driven inputs and update the model.
    task automatic cycle();
        logic acc;
        exp_t nexp;
        acc  = in_valid && (!m_valid || out_ready);
        nexp = predict(instr);
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1'b1;
            m_exp   = nexp;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        instr     = 32'h0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        out_ready = 1'b1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        cycle();
        wb_en    = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        instr     = ins;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
        total++;
        if (got_vec() !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", got_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        write_reg(5'd5, 32'h1234);
        issue(32'h00A01820);
        total++;
        if (out_valid !== 1'b1 || out_rs_data !== 32'h1234 || out_rt_data !== 32'h0 ||
            out_dst !== 5'd3 || out_ctrl !== (C_REGDST | C_REGWRITE | 10'd2)) begin
            bad++;
            $display("FAIL rtype_add got v=%b rs=%h rt=%h dst=%0d ctrl=%b exp v=1 rs=1234 rt=0 dst=3 ctrl=%b",
                     out_valid, out_rs_data, out_rt_data, out_dst, out_ctrl, C_REGDST | C_REGWRITE | 10'd2);
        end
        total++;
        if (got_vec() !== m_exp) begin
            bad++;
            $display("FAIL rtype_model got=%h exp=%h", got_vec(), m_exp);
        end
        cycle();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rtype_drain got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_lw();
        write_reg(5'd2, 32'h0000_1000);
        issue(32'h8C47FFFC);
        total++;
        if (out_imm !== 32'hFFFF_FFFC || out_dst !== 5'd7 || out_illegal !== 1'b0 ||
            out_ctrl !== (C_ALUSRC | C_MEMREAD | C_MEMTOREG | C_REGWRITE) || out_rs_data !== 32'h1000) begin
            bad++;
            $display("FAIL lw_decode got imm=%h dst=%0d ctrl=%b rs=%h ill=%b exp imm=fffffffc dst=7 ctrl=%b rs=1000 ill=0",
                     out_imm, out_dst, out_ctrl, out_rs_data, out_illegal,
                     C_ALUSRC | C_MEMREAD | C_MEMTOREG | C_REGWRITE);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        write_reg(5'd9, 32'h55);
        wb_en    = 1'b1;
        wb_addr  = 5'd9;
        wb_data  = 32'hAA;
        issue({6'd0, 5'd9, 5'd9, 5'd1, 5'd0, 6'h20});
        wb_en    = 1'b0;
`ifdef REG_READ_BYPASS_EN
        want = 32'hAA;
`else
        want = 32'h55;
`endif
        total++;
        if (out_rs_data !== want || out_rt_data !== want) begin
            bad++;
            $display("FAIL bypass_same_cycle got rs=%h rt=%h exp=%h", out_rs_data, out_rt_data, want);
        end
        issue({6'd0, 5'd9, 5'd0, 5'd1, 5'd0, 6'h20});
        total++;
        if (out_rs_data !== 32'hAA) begin
            bad++;
            $display("FAIL bypass_after got rs=%h exp=000000aa", out_rs_data);
        end
    endtask

    task automatic test_stall();
        exp_t held;
        write_reg(5'd12, 32'h100);
        issue({6'd0, 5'd12, 5'd0, 5'd4, 5'd0, 6'h20});
        held      = got_vec();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = {6'b100011, 5'd12, 5'd13, 16'h0008};
        for (int i = 0; i < 3; i++) begin
            wb_en   = 1'b1;
            wb_addr = 5'd12;
            wb_data = 32'h200 + i;
            cycle();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got_vec() !== m_exp || got_vec() !== held) begin
                bad++;
                $display("FAIL stall_hold_%0d got v=%b rdy=%b out=%h exp v=1 rdy=0 out=%h",
                         i, out_valid, in_ready, got_vec(), m_exp);
            end
        end
        wb_en     = 1'b0;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        total++;
        if (out_valid !== 1'b1 || got_vec() !== m_exp || out_rs_data !== 32'h202) begin
            bad++;
            $display("FAIL stall_release got v=%b out=%h exp v=1 out=%h", out_valid, got_vec(), m_exp);
        end
    endtask

    task automatic test_illegal();
        issue({6'b111111, 5'd3, 5'd4, 16'h1234});
        total++;
        if (out_illegal !== 1'b1 || out_ctrl !== 10'h0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL illegal_op got ill=%b ctrl=%b v=%b exp ill=1 ctrl=0 v=1", out_illegal, out_ctrl, out_valid);
        end
        write_reg(5'd0, 32'hDEAD);
        issue({6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20});
        total++;
        if (out_rs_data !== 32'h0 || out_rt_data !== 32'h0) begin
            bad++;
            $display("FAIL r0_zero got rs=%h rt=%h exp 0", out_rs_data, out_rt_data);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(5'd20, 32'hCAFE);
        instr     = {6'd0, 5'd20, 5'd20, 5'd2, 5'd0, 6'h20};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cycle();
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_vec() !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_mid got v=%b rdy=%b out=%h exp v=0 rdy=1 out=0", out_valid, in_ready, got_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue({6'd0, 5'd20, 5'd20, 5'd2, 5'd0, 6'h20});
        total++;
        if (out_rs_data !== 32'h0 || out_rt_data !== 32'h0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_regs got rs=%h rt=%h v=%b exp rs=0 rt=0 v=1", out_rs_data, out_rt_data, out_valid);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic       exp_rdy;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000000};
        for (int n = 0; n < 300; n++) begin
            ops[5]    = 6'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = {ops[$urandom_range(0, 5)], 26'($urandom)};
            out_ready = ($urandom_range(0, 2) != 0);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_addr   = 5'($urandom);
            wb_data   = $urandom;
            #1;
            exp_rdy = !m_valid || out_ready;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rand_ready_%0d got=%b exp=%b", n, in_ready, exp_rdy);
            end
            cycle();
            total++;
            if (out_valid !== m_valid || (m_valid && got_vec() !== m_exp)) begin
                bad++;
                $display("FAIL rand_out_%0d got v=%b out=%h exp v=%b out=%h", n, out_valid, got_vec(), m_valid, m_exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_bypass();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
